// File: rtl/seq_pkg.sv
// Types and constants shared by the 1011 serial transmitter and the matching detector.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    GAP
  } tx_state_t;

  localparam logic [3:0] PREAMBLE     = 4'b1011;
  localparam int         PREAMBLE_LEN = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Parallel-in / serial-out shift register: load a word, shift left, expose the MSB.
module seq_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[DATA_W-1];

endmodule

// File: rtl/seq_tx_1011.sv
// Framed serial transmitter: optional 1011 preamble, MSB-first payload, idle guard gap.
// Preamble is present only when SEQ_TX_PREAMBLE_EN is defined.
module seq_tx_1011
  import seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              x,
  output logic              x_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(max3(PREAMBLE_LEN, DATA_W, GAP_LEN) + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  // The final guard cycle is spent in IDLE with busy still high, so GAP
  // itself holds one cycle fewer; that lets a new word be taken on the
  // edge that ends the guard time.
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'((GAP_LEN > 1) ? (GAP_LEN - 2) : 0);
`ifdef SEQ_TX_PREAMBLE_EN
  localparam logic [CNT_W-1:0] LAST_PRE  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [1:0]       PRE_TOP   = 2'(PREAMBLE_LEN - 2);
`endif

  tx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              x_q, x_d;
  logic              x_valid_q, x_valid_d;
  logic              busy_q, busy_d;
  logic              hs;
  logic              shift_en;
  logic              shf_msb;
  logic [DATA_W-1:0] load_val;

  assign data_ready = (state_q == IDLE);
  assign hs         = data_valid && data_ready;

`ifdef SEQ_TX_PREAMBLE_EN
  assign load_val = data_in;
`else
  // MSB goes straight to x on the handshake edge, so the shifter starts at bit DATA_W-2.
  assign load_val = data_in << 1;
`endif

  seq_tx_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (hs),
    .shift  (shift_en),
    .din    (load_val),
    .msb    (shf_msb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          busy_d    = 1'b1;
          x_valid_d = 1'b1;
          cnt_d     = '0;
`ifdef SEQ_TX_PREAMBLE_EN
          state_d   = PRE;
          x_d       = PREAMBLE[PREAMBLE_LEN-1];
`else
          state_d   = DATA;
          x_d       = data_in[DATA_W-1];
`endif
        end
      end
`ifdef SEQ_TX_PREAMBLE_EN
      PRE: begin
        busy_d    = 1'b1;
        x_valid_d = 1'b1;
        if (cnt_q == LAST_PRE) begin
          state_d  = DATA;
          cnt_d    = '0;
          x_d      = shf_msb;
          shift_en = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          x_d   = PREAMBLE[PRE_TOP - cnt_q[1:0]];
        end
      end
`endif
      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_DATA) begin
          cnt_d   = '0;
          state_d = (GAP_LEN > 1) ? GAP : IDLE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          x_valid_d = 1'b1;
          x_d       = shf_msb;
          shift_en  = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_GAP) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seq_tx_1011.sv
// Self-checking bench for seq_tx_1011 against a per-cycle frame queue model.
module tb_seq_tx_1011;

  localparam int DATA_W  = 8;
  localparam int GAP_LEN = 2;
`ifdef SEQ_TX_PREAMBLE_EN
  localparam int PRE_LEN = 4;
`else
  localparam int PRE_LEN = 0;
`endif
  localparam int FRAME_LEN = PRE_LEN + DATA_W + GAP_LEN;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic              x;
  logic              x_valid;
  logic              busy;

  int pass_cnt = 0;
  int total    = 0;

  // Expected per-cycle output entries {busy, x_valid, x}, front = current cycle.
  logic [2:0] mq[$];

  always #5 clk = ~clk;

  seq_tx_1011 #(
    .DATA_W (DATA_W),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [3:0] pre;
    pre = 4'b1011;
    for (int i = 0; i < PRE_LEN; i++) mq.push_back({2'b11, pre[3-i]});
    for (int i = DATA_W - 1; i >= 0; i--) mq.push_back({2'b11, d[i]});
    for (int i = 0; i < GAP_LEN; i++) mq.push_back(3'b100);
  endtask

  // Drives one cycle of stimulus; returns observed/expected {ready,busy,x_valid,x}.
  task automatic step(input logic v, input logic [DATA_W-1:0] d,
                      output logic [3:0] obs, output logic [3:0] exp);
    logic rdy_m;
    data_valid = v;
    data_in    = d;
    @(negedge clk);
    rdy_m = (mq.size() <= 1);
    exp   = {rdy_m, (mq.size() > 0) ? mq[0] : 3'b000};
    obs   = {data_ready, busy, x_valid, x};
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    if (v && rdy_m) push_frame(d);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({data_ready, busy, x_valid, x} !== 4'b1000) begin
      $display("FAIL reset_state got %b exp 1000", {data_ready, busy, x_valid, x});
    end else pass_cnt++;
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    data_valid = 1'b0;
    mq.delete();
  endtask

  task automatic test_a5();
    logic [3:0] o, e;
    int busy_n;
    busy_n = 0;
    step(1'b1, 8'hA5, o, e);
    for (int i = 0; i < FRAME_LEN + 3; i++) begin
      step(1'b0, 8'h00, o, e);
      if (o[2]) busy_n++;
      total++;
      if (o !== e) $display("FAIL a5 cyc %0d got %b exp %b", i, o, e);
      else pass_cnt++;
    end
    total++;
    if (busy_n !== FRAME_LEN) $display("FAIL a5_busy_len got %0d exp %0d", busy_n, FRAME_LEN);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] o, e;
    int rdy_n, second_start;
    rdy_n = 0;
    second_start = -1;
    step(1'b1, 8'hFF, o, e);
    for (int i = 0; i < 2 * FRAME_LEN + 2; i++) begin
      step(i < FRAME_LEN, 8'h00, o, e);
      if (i < FRAME_LEN && o[3]) rdy_n++;
      if (i >= FRAME_LEN && o[1] && second_start < 0) second_start = i;
      total++;
      if (o !== e) $display("FAIL b2b cyc %0d got %b exp %b", i, o, e);
      else pass_cnt++;
    end
    total++;
    if (rdy_n !== 1) $display("FAIL b2b_ready_count got %0d exp 1", rdy_n);
    else pass_cnt++;
    total++;
    if (second_start !== FRAME_LEN) $display("FAIL b2b_second_start got %0d exp %0d", second_start, FRAME_LEN);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] o, e;
    step(1'b1, 8'h55, o, e);
    for (int i = 0; i < PRE_LEN + 2; i++) step(1'b0, 8'h00, o, e);
    #2;
    total++;
    if ({busy, x_valid} !== 2'b11) $display("FAIL midrst_pre got %b exp 11", {busy, x_valid});
    else pass_cnt++;
    reset_n    = 1'b0;
    data_valid = 1'b1;
    #1;
    total++;
    if ({data_ready, busy, x_valid, x} !== 4'b1000) begin
      $display("FAIL midrst_immediate got %b exp 1000", {data_ready, busy, x_valid, x});
    end else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, x_valid, x} !== 3'b000) $display("FAIL midrst_hs_ignored got %b exp 000", {busy, x_valid, x});
    else pass_cnt++;
    reset_n    = 1'b1;
    data_valid = 1'b0;
    mq.delete();
    step(1'b1, 8'h0F, o, e);
    for (int i = 0; i < FRAME_LEN + 2; i++) begin
      step(1'b0, 8'h00, o, e);
      total++;
      if (o !== e) $display("FAIL midrst_frame cyc %0d got %b exp %b", i, o, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_data_change();
    logic [3:0] o, e;
    logic [DATA_W-1:0] got;
    got = '0;
    step(1'b1, 8'h3C, o, e);
    for (int i = 0; i < FRAME_LEN + 2; i++) begin
      step(1'b0, 8'hC3, o, e);
      if (o[1] && i >= PRE_LEN && i < PRE_LEN + DATA_W) got = {got[DATA_W-2:0], o[0]};
      total++;
      if (o !== e) $display("FAIL hold cyc %0d got %b exp %b", i, o, e);
      else pass_cnt++;
    end
    total++;
    if (got !== 8'h3C) $display("FAIL hold_payload got %h exp 3c", got);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] o, e;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, DATA_W'($urandom), o, e);
      total++;
      if (o !== e) $display("FAIL random cyc %0d got %b exp %b", i, o, e);
      else pass_cnt++;
    end
    for (int i = 0; i < FRAME_LEN + 2; i++) step(1'b0, 8'h00, o, e);
  endtask

  task automatic test_detector();
`ifdef SEQ_TX_PREAMBLE_EN
    logic [3:0] o, e;
    logic [3:0] win;
    int hits, first_hit;
    win = '0;
    hits = 0;
    first_hit = -1;
    step(1'b1, 8'h00, o, e);
    for (int i = 0; i < 3 * FRAME_LEN + 2; i++) begin
      step(i < 2 * FRAME_LEN, 8'h00, o, e);
      win = {win[2:0], o[0]};
      if (win == 4'b1011) begin
        hits++;
        if (first_hit < 0) first_hit = i;
      end
    end
    total++;
    if (hits !== 3) $display("FAIL detect_count got %0d exp 3", hits);
    else pass_cnt++;
    total++;
    if (first_hit !== 3) $display("FAIL detect_position got %0d exp 3", first_hit);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_reset_mid();
    test_data_change();
    test_random();
    test_detector();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
